// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: program counter, imem address and the IF/ID pipeline latch,
// with redirect/hold priority and saturating stall/flush counters for performance debug.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IF_IDhold,
    input  logic             Branch,
    input  logic [31:0]      BranchTarget,
    input  logic             Jump,
    input  logic [31:0]      JumpTarget,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      IF_IDinstr,
    output logic [31:0]      IF_IDpc4,
    output logic             IF_IDvalid,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;
    localparam logic [31:0] PC_INC           = 32'(PC_STEP);
    localparam logic [31:0] LINK_INC         = 32'd4;

    logic [31:0]      pc;
    logic [31:0]      pc_next;
    logic [31:0]      instr_next;
    logic [31:0]      pc4_next;
    logic             valid_next;
    logic [CNT_W-1:0] stall_next;
    logic [CNT_W-1:0] flush_next;
    logic             redirect;
    logic [31:0]      redirect_target;

    // Jump is resolved later than branch in the pipe, so it wins a tie.
    assign redirect        = Jump | Branch;
    assign redirect_target = Jump ? JumpTarget : BranchTarget;

    assign imem_addr = pc;

    // Priority mux: redirect > hold > advance.
    always_comb begin
        pc_next    = pc;
        instr_next = IF_IDinstr;
        pc4_next   = IF_IDpc4;
        valid_next = IF_IDvalid;
        stall_next = stall_count;
        flush_next = flush_count;

        if (redirect) begin
            pc_next    = redirect_target & ~32'h3;
            instr_next = 32'h0;
            pc4_next   = 32'h0;
            valid_next = 1'b0;
            if (flush_count != {CNT_W{1'b1}}) begin
                flush_next = flush_count + CNT_W'(1);
            end
        end else if (IF_IDhold) begin
            if (stall_count != {CNT_W{1'b1}}) begin
                stall_next = stall_count + CNT_W'(1);
            end
        end else begin
            pc_next    = pc + PC_INC;
            instr_next = imem_data;
            pc4_next   = pc + LINK_INC;
            valid_next = 1'b1;
        end
    end

    // State registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC_ALIGNED;
            IF_IDinstr  <= 32'h0;
            IF_IDpc4    <= 32'h0;
            IF_IDvalid  <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            pc          <= pc_next;
            IF_IDinstr  <= instr_next;
            IF_IDpc4    <= pc4_next;
            IF_IDvalid  <= valid_next;
            stall_count <= stall_next;
            flush_count <= flush_next;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: imem returns 0x1000_0000 + address, counters are 4 bits
// so saturation is reachable in a short run.
module tb_if_fetch_stage;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             IF_IDhold;
    logic             Branch;
    logic [31:0]      BranchTarget;
    logic             Jump;
    logic [31:0]      JumpTarget;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_data;
    logic [31:0]      IF_IDinstr;
    logic [31:0]      IF_IDpc4;
    logic             IF_IDvalid;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    int checks = 0;
    int errors = 0;

    if_fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .IF_IDhold   (IF_IDhold),
        .Branch      (Branch),
        .BranchTarget(BranchTarget),
        .Jump        (Jump),
        .JumpTarget  (JumpTarget),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .IF_IDinstr  (IF_IDinstr),
        .IF_IDpc4    (IF_IDpc4),
        .IF_IDvalid  (IF_IDvalid),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    assign imem_data = 32'h1000_0000 + imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge; inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; IF_IDhold = 1'b0; Branch = 1'b0; Jump = 1'b0;
        BranchTarget = 32'h0; JumpTarget = 32'h0;
        tick(); tick();
        checks++;
        if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, 32'h0); end
        checks++;
        if (IF_IDinstr !== 32'h0 || IF_IDpc4 !== 32'h0 || IF_IDvalid !== 1'b0) begin
            errors++; $display("FAIL reset_ifid: got instr=%h pc4=%h valid=%b expected 0/0/0", IF_IDinstr, IF_IDpc4, IF_IDvalid);
        end
        checks++;
        if (stall_count !== 4'h0 || flush_count !== 4'h0) begin
            errors++; $display("FAIL reset_counts: got stall=%h flush=%h expected 0/0", stall_count, flush_count);
        end
    endtask

    task automatic test_sequential();
        rst_n = 1'b1;
        tick();
        checks++;
        if (imem_addr !== 32'h4) begin errors++; $display("FAIL seq_addr1: got %h expected %h", imem_addr, 32'h4); end
        tick();
        checks++;
        if (imem_addr !== 32'h8) begin errors++; $display("FAIL seq_addr2: got %h expected %h", imem_addr, 32'h8); end
        tick();
        checks++;
        if (imem_addr !== 32'hC) begin errors++; $display("FAIL seq_addr3: got %h expected %h", imem_addr, 32'hC); end
        checks++;
        if (IF_IDinstr !== 32'h1000_0008 || IF_IDpc4 !== 32'hC || IF_IDvalid !== 1'b1) begin
            errors++; $display("FAIL seq_ifid: got instr=%h pc4=%h valid=%b expected 10000008/0000000c/1", IF_IDinstr, IF_IDpc4, IF_IDvalid);
        end
    endtask

    task automatic test_hold();
        tick();
        IF_IDhold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (imem_addr !== 32'h10 || IF_IDinstr !== 32'h1000_000C || IF_IDpc4 !== 32'h10 || IF_IDvalid !== 1'b1) begin
                errors++; $display("FAIL hold_freeze%0d: got addr=%h instr=%h pc4=%h valid=%b expected 00000010/1000000c/00000010/1",
                                   i, imem_addr, IF_IDinstr, IF_IDpc4, IF_IDvalid);
            end
        end
        checks++;
        if (stall_count !== 4'h2) begin errors++; $display("FAIL hold_stall_count: got %h expected %h", stall_count, 4'h2); end
        IF_IDhold = 1'b0;
        tick();
        checks++;
        if (IF_IDpc4 !== 32'h14 || IF_IDinstr !== 32'h1000_0010 || imem_addr !== 32'h14) begin
            errors++; $display("FAIL hold_release: got pc4=%h instr=%h addr=%h expected 00000014/10000010/00000014", IF_IDpc4, IF_IDinstr, imem_addr);
        end
    endtask

    task automatic test_branch_over_hold();
        IF_IDhold = 1'b1; Branch = 1'b1; BranchTarget = 32'h0000_0203;
        tick();
        checks++;
        if (imem_addr !== 32'h200) begin errors++; $display("FAIL br_addr: got %h expected %h", imem_addr, 32'h200); end
        checks++;
        if (IF_IDvalid !== 1'b0 || IF_IDinstr !== 32'h0 || IF_IDpc4 !== 32'h0) begin
            errors++; $display("FAIL br_squash: got valid=%b instr=%h pc4=%h expected 0/0/0", IF_IDvalid, IF_IDinstr, IF_IDpc4);
        end
        checks++;
        if (flush_count !== 4'h1 || stall_count !== 4'h2) begin
            errors++; $display("FAIL br_counts: got flush=%h stall=%h expected 1/2", flush_count, stall_count);
        end
        IF_IDhold = 1'b0; Branch = 1'b0;
        tick();
        checks++;
        if (IF_IDinstr !== 32'h1000_0200 || IF_IDpc4 !== 32'h204 || IF_IDvalid !== 1'b1) begin
            errors++; $display("FAIL br_target_fetch: got instr=%h pc4=%h valid=%b expected 10000200/00000204/1", IF_IDinstr, IF_IDpc4, IF_IDvalid);
        end
    endtask

    task automatic test_jump_priority();
        Jump = 1'b1; JumpTarget = 32'h400; Branch = 1'b1; BranchTarget = 32'h800;
        tick();
        checks++;
        if (imem_addr !== 32'h400) begin errors++; $display("FAIL jmp_prio_addr: got %h expected %h", imem_addr, 32'h400); end
        checks++;
        if (flush_count !== 4'h2) begin errors++; $display("FAIL jmp_prio_flush: got %h expected %h", flush_count, 4'h2); end
        Jump = 1'b0; Branch = 1'b0;
    endtask

    task automatic test_wrap();
        Jump = 1'b1; JumpTarget = 32'hFFFF_FFFF;
        tick();
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align: got %h expected %h", imem_addr, 32'hFFFF_FFFC); end
        Jump = 1'b0;
        tick();
        checks++;
        if (imem_addr !== 32'h0 || IF_IDpc4 !== 32'h0 || IF_IDinstr !== 32'h0FFF_FFFC || IF_IDvalid !== 1'b1) begin
            errors++; $display("FAIL wrap_advance: got addr=%h pc4=%h instr=%h valid=%b expected 0/0/0ffffffc/1",
                               imem_addr, IF_IDpc4, IF_IDinstr, IF_IDvalid);
        end
        checks++;
        if (flush_count !== 4'h3) begin errors++; $display("FAIL wrap_flush: got %h expected %h", flush_count, 4'h3); end
    endtask

    task automatic test_reset_mid_stall();
        tick(); tick();
        IF_IDhold = 1'b1;
        tick();
        rst_n = 1'b0; Branch = 1'b1; BranchTarget = 32'h0000_0600;
        tick();
        checks++;
        if (imem_addr !== 32'h0 || IF_IDinstr !== 32'h0 || IF_IDpc4 !== 32'h0 || IF_IDvalid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ifid: got addr=%h instr=%h pc4=%h valid=%b expected 0/0/0/0",
                               imem_addr, IF_IDinstr, IF_IDpc4, IF_IDvalid);
        end
        checks++;
        if (stall_count !== 4'h0 || flush_count !== 4'h0) begin
            errors++; $display("FAIL rst_mid_counts: got stall=%h flush=%h expected 0/0", stall_count, flush_count);
        end
        rst_n = 1'b1; IF_IDhold = 1'b0; Branch = 1'b0;
        tick();
        checks++;
        if (IF_IDinstr !== 32'h1000_0000 || IF_IDpc4 !== 32'h4 || imem_addr !== 32'h4) begin
            errors++; $display("FAIL rst_mid_refetch: got instr=%h pc4=%h addr=%h expected 10000000/00000004/00000004", IF_IDinstr, IF_IDpc4, imem_addr);
        end
    endtask

    task automatic test_saturation();
        IF_IDhold = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (stall_count !== 4'hE) begin errors++; $display("FAIL sat_stall_pre: got %h expected %h", stall_count, 4'hE); end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (stall_count !== 4'hF || imem_addr !== 32'h4) begin
            errors++; $display("FAIL sat_stall: got stall=%h addr=%h expected f/00000004", stall_count, imem_addr);
        end
        IF_IDhold = 1'b0; Jump = 1'b1; JumpTarget = 32'h100;
        for (int i = 0; i < 17; i++) tick();
        checks++;
        if (flush_count !== 4'hF || stall_count !== 4'hF) begin
            errors++; $display("FAIL sat_flush: got flush=%h stall=%h expected f/f", flush_count, stall_count);
        end
        Jump = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; IF_IDhold = 1'b0; Branch = 1'b0; Jump = 1'b0;
        BranchTarget = 32'h0; JumpTarget = 32'h0;
        @(negedge clk);
        test_reset();
        checks++;
        if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_fetch_addr: got %h expected %h", imem_addr, 32'h0); end
        test_sequential();
        test_hold();
        test_branch_over_hold();
        test_jump_priority();
        test_wrap();
        test_reset_mid_stall();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
